// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and its load aligner.
package wb_pkg;

    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_REG_ADDR_W = 5;

    // IDLE accepts from execute; REQ presents the read; WAIT holds for data.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } wb_state_e;

    // RV32I load funct3 encodings.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // A load is legal when funct3 is a known load type and the byte
    // offset is naturally aligned for the access size.
    function automatic logic load_legal(input logic [2:0] funct3,
                                        input logic [1:0] offset);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = (offset[0] == 1'b0);
            F3_LW:         ok = (offset == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Selects the addressed byte/half lane of a read word and extends it
// according to the load type. Purely combinational.
module load_aligner
    import wb_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select, then sign/zero extension by load type.
    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        data_o   = 32'h0000_0000;

        case (offset_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase

        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data_o = rdata_i;
            F3_LBU:  data_o = {24'h000000, byte_sel};
            F3_LHU:  data_o = {16'h0000, half_sel};
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: forwards ALU results to the register file write
// port and performs single-outstanding data-memory loads.
//
// Handshakes: an execute transfer happens on a cycle where ex_valid_i and
// ex_ready_o are both high; ex_ready_o is high only in IDLE. A memory
// request is accepted on a cycle where mem_req_o and mem_gnt_i are both
// high; mem_addr_o is stable while mem_req_o waits for the grant. Read
// data is taken on the first mem_rvalid_i seen in WAIT; rvalid outside
// WAIT and gnt outside REQ are ignored.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic                  ex_reg_write_i,
    input  logic                  ex_is_load_i,
    input  logic [2:0]            ex_funct3_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [DATA_W-1:0]     ex_result_i,

    output logic                  mem_req_o,
    output logic [DATA_W-1:0]     mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,

    output logic                  rf_write_o,
    output logic [REG_ADDR_W-1:0] rf_write_reg_o,
    output logic [DATA_W-1:0]     rf_write_data_o,

    output logic                  load_err_o
);

    wb_state_e             state_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  reg_write_q;
    logic [2:0]            funct3_q;
    logic [1:0]            offset_q;
    logic [DATA_W-1:0]     addr_q;

    logic                  rf_write_q;
    logic [REG_ADDR_W-1:0] rf_reg_q;
    logic [DATA_W-1:0]     rf_data_q;
    logic                  load_err_q;

    logic                  accept;
    logic [DATA_W-1:0]     load_data;

    assign accept = ex_valid_i && (state_q == IDLE);

    load_aligner u_load_aligner (
        .rdata_i  (mem_rdata_i),
        .funct3_i (funct3_q),
        .offset_i (offset_q),
        .data_o   (load_data)
    );

    // Control FSM with registered write-port and error outputs; pulses
    // default low every cycle, write index/data hold between writes.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
            addr_q      <= '0;
            rf_write_q  <= 1'b0;
            rf_reg_q    <= '0;
            rf_data_q   <= '0;
            load_err_q  <= 1'b0;
        end else begin
            rf_write_q <= 1'b0;
            load_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (!ex_is_load_i) begin
                            if (ex_reg_write_i && (ex_rd_i != '0)) begin
                                rf_write_q <= 1'b1;
                                rf_reg_q   <= ex_rd_i;
                                rf_data_q  <= ex_result_i;
                            end
                        end else if (!load_legal(ex_funct3_i, ex_result_i[1:0])) begin
                            load_err_q <= 1'b1;
                        end else begin
                            rd_q        <= ex_rd_i;
                            reg_write_q <= ex_reg_write_i;
                            funct3_q    <= ex_funct3_i;
                            offset_q    <= ex_result_i[1:0];
                            addr_q      <= {ex_result_i[DATA_W-1:2], 2'b00};
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        if (reg_write_q && (rd_q != '0)) begin
                            rf_write_q <= 1'b1;
                            rf_reg_q   <= rd_q;
                            rf_data_q  <= load_data;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex_ready_o      = (state_q == IDLE);
    assign mem_req_o       = (state_q == REQ);
    assign mem_addr_o      = addr_q;
    assign rf_write_o      = rf_write_q;
    assign rf_write_reg_o  = rf_reg_q;
    assign rf_write_data_o = rf_data_q;
    assign load_err_o      = load_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus a
// randomized run compared against a behavioural load/writeback model.
module tb_writeback_stage;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic        ex_reg_write_i;
    logic        ex_is_load_i;
    logic [2:0]  ex_funct3_i;
    logic [4:0]  ex_rd_i;
    logic [31:0] ex_result_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        rf_write_o;
    logic [4:0]  rf_write_reg_o;
    logic [31:0] rf_write_data_o;
    logic        load_err_o;

    int checks   = 0;
    int failures = 0;

    // Model of the register-file write port contents between writes.
    logic [4:0]  last_reg;
    logic [31:0] last_data;

    writeback_stage dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .ex_valid_i      (ex_valid_i),
        .ex_ready_o      (ex_ready_o),
        .ex_reg_write_i  (ex_reg_write_i),
        .ex_is_load_i    (ex_is_load_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_rd_i         (ex_rd_i),
        .ex_result_i     (ex_result_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i),
        .rf_write_o      (rf_write_o),
        .rf_write_reg_o  (rf_write_reg_o),
        .rf_write_data_o (rf_write_data_o),
        .load_err_o      (load_err_o)
    );

    // Clock: 10 time-unit period; DUT acts on posedge, bench on negedge.
    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic int load_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = load_size(f3);
        if (sz == 0) return 1'b0;
        return (addr % sz) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [31:0] addr);
        logic [31:0] shifted;
        longint      v;
        shifted = word >> (8 * (addr % 4));
        case (f3)
            3'b000: begin
                v = shifted % 256;
                if (v >= 128) v = v - 256;
                return 32'(v);
            end
            3'b001: begin
                v = shifted % 65536;
                if (v >= 32768) v = v - 65536;
                return 32'(v);
            end
            3'b100:  return shifted % 256;
            3'b101:  return shifted % 65536;
            default: return word;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        last_reg  = 5'd0;
        last_data = 32'd0;
    endtask

    // Present one instruction for one cycle; returns at the negedge after
    // the accepting posedge.
    task automatic issue(input bit is_load, input bit rw, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] res);
        ex_is_load_i   = is_load;
        ex_reg_write_i = rw;
        ex_funct3_i    = f3;
        ex_rd_i        = rd;
        ex_result_i    = res;
        ex_valid_i     = 1'b1;
        @(negedge clk_i);
        ex_valid_i     = 1'b0;
        ex_result_i    = $urandom;
    endtask

    // Complete a legal load with given grant and rvalid delays.
    task automatic serve_mem(input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        repeat (gnt_dly) @(negedge clk_i);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        repeat (rv_dly) @(negedge clk_i);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rdata;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk_i);
        checks++;
        if (ex_ready_o !== 1'b1 || mem_req_o !== 1'b0 || rf_write_o !== 1'b0 ||
            load_err_o !== 1'b0 || mem_addr_o !== 32'd0 ||
            rf_write_reg_o !== 5'd0 || rf_write_data_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b req=%b wr=%b err=%b addr=%h reg=%0d data=%h, required ready=1 others 0",
                     ex_ready_o, mem_req_o, rf_write_o, load_err_o, mem_addr_o, rf_write_reg_o, rf_write_data_o);
        end
        reset_i = 1'b0;
        last_reg  = 5'd0;
        last_data = 32'd0;
    endtask

    task automatic test_alu();
        issue(1'b0, 1'b1, 3'b000, 5'd5, 32'hDEADBEEF);
        checks++;
        if (rf_write_o !== 1'b1 || rf_write_reg_o !== 5'd5 || rf_write_data_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL alu_write: wr=%b reg=%0d data=%h, required 1 5 deadbeef",
                     rf_write_o, rf_write_reg_o, rf_write_data_o);
        end
        @(negedge clk_i);
        checks++;
        if (rf_write_o !== 1'b0 || rf_write_data_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL alu_pulse_hold: wr=%b data=%h, required 0 deadbeef", rf_write_o, rf_write_data_o);
        end
        issue(1'b0, 1'b1, 3'b000, 5'd0, 32'h1234_5678);
        checks++;
        if (rf_write_o !== 1'b0 || rf_write_reg_o !== 5'd5 || rf_write_data_o !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL alu_x0: wr=%b reg=%0d data=%h, required 0 5 deadbeef",
                     rf_write_o, rf_write_reg_o, rf_write_data_o);
        end
        issue(1'b0, 1'b0, 3'b000, 5'd9, 32'h1111_2222);
        checks++;
        if (rf_write_o !== 1'b0) begin
            failures++;
            $display("FAIL alu_no_regwrite: wr=%b, required 0", rf_write_o);
        end
        last_reg  = 5'd5;
        last_data = 32'hDEADBEEF;
    endtask

    task automatic test_loads();
        logic [2:0]  f3   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] addr [5] = '{32'h1003, 32'h1003, 32'h2002, 32'h2002, 32'h2000};
        logic [31:0] rdat [5] = '{32'h80FF1234, 32'h80FF1234, 32'h9ABC5678, 32'h9ABC5678, 32'h9ABC5678};
        logic [31:0] exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF9ABC, 32'h00009ABC, 32'h9ABC5678};
        logic [31:0] exp_addr;
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 1'b1, f3[i], 5'(10 + i), addr[i]);
            exp_addr = addr[i] & 32'hFFFF_FFFC;
            checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== exp_addr || ex_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL load_req[%0d]: req=%b addr=%h ready=%b, required 1 %h 0",
                         i, mem_req_o, mem_addr_o, ex_ready_o, exp_addr);
            end
            serve_mem(0, 0, rdat[i]);
            checks++;
            if (rf_write_o !== 1'b1 || rf_write_reg_o !== 5'(10 + i) || rf_write_data_o !== exp[i] ||
                ex_ready_o !== 1'b1) begin
                failures++;
                $display("FAIL load_data[%0d]: wr=%b reg=%0d data=%h ready=%b, required 1 %0d %h 1",
                         i, rf_write_o, rf_write_reg_o, rf_write_data_o, ex_ready_o, 10 + i, exp[i]);
            end
        end
        last_reg  = 5'd14;
        last_data = 32'h9ABC5678;
    endtask

    task automatic test_illegal();
        logic [2:0]  f3   [2] = '{3'b010, 3'b011};
        logic [31:0] addr [2] = '{32'h2001, 32'h2000};
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, 1'b1, f3[i], 5'd3, addr[i]);
            checks++;
            if (load_err_o !== 1'b1 || mem_req_o !== 1'b0 || rf_write_o !== 1'b0 || ex_ready_o !== 1'b1) begin
                failures++;
                $display("FAIL illegal_load[%0d]: err=%b req=%b wr=%b ready=%b, required 1 0 0 1",
                         i, load_err_o, mem_req_o, rf_write_o, ex_ready_o);
            end
            @(negedge clk_i);
            checks++;
            if (load_err_o !== 1'b0 || mem_req_o !== 1'b0 || rf_write_o !== 1'b0) begin
                failures++;
                $display("FAIL illegal_after[%0d]: err=%b req=%b wr=%b, required 0 0 0",
                         i, load_err_o, mem_req_o, rf_write_o);
            end
        end
    endtask

    task automatic test_gnt_delay();
        issue(1'b1, 1'b1, 3'b100, 5'd7, 32'h0000_3002);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h3000 || ex_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL gnt_wait[%0d]: req=%b addr=%h ready=%b, required 1 00003000 0",
                         c, mem_req_o, mem_addr_o, ex_ready_o);
            end
            @(negedge clk_i);
        end
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b0 || ex_ready_o !== 1'b0 || rf_write_o !== 1'b0) begin
            failures++;
            $display("FAIL wait_state: req=%b ready=%b wr=%b, required 0 0 0", mem_req_o, ex_ready_o, rf_write_o);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h00AB_0000;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        checks++;
        if (rf_write_o !== 1'b1 || rf_write_reg_o !== 5'd7 || rf_write_data_o !== 32'h0000_00AB) begin
            failures++;
            $display("FAIL gnt_delay_data: wr=%b reg=%0d data=%h, required 1 7 000000ab",
                     rf_write_o, rf_write_reg_o, rf_write_data_o);
        end
        // Stray memory responses while idle must be ignored.
        mem_rvalid_i = 1'b1;
        mem_gnt_i    = 1'b1;
        mem_rdata_i  = 32'hFFFF_FFFF;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b0;
        @(negedge clk_i);
        checks++;
        if (rf_write_o !== 1'b0 || ex_ready_o !== 1'b1 || mem_req_o !== 1'b0 ||
            rf_write_data_o !== 32'h0000_00AB) begin
            failures++;
            $display("FAIL stray_rvalid: wr=%b ready=%b req=%b data=%h, required 0 1 0 000000ab",
                     rf_write_o, ex_ready_o, mem_req_o, rf_write_data_o);
        end
    endtask

    task automatic test_reset_inflight();
        // Reset while requesting: request must drop without a clock edge.
        issue(1'b1, 1'b1, 3'b010, 5'd8, 32'h0000_4000);
        reset_i = 1'b1;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || ex_ready_o !== 1'b1 || rf_write_data_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_in_req: req=%b ready=%b data=%h, required 0 1 0", mem_req_o, ex_ready_o, rf_write_data_o);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        // Reset while waiting for data; late rvalid must not write.
        issue(1'b1, 1'b1, 3'b010, 5'd8, 32'h0000_4000);
        mem_gnt_i = 1'b1;
        @(negedge clk_i);
        mem_gnt_i = 1'b0;
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b0 || ex_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_wait: req=%b ready=%b, required 0 1", mem_req_o, ex_ready_o);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5555_AAAA;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        checks++;
        if (rf_write_o !== 1'b0 || ex_ready_o !== 1'b1 || rf_write_data_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_late_rvalid: wr=%b ready=%b data=%h, required 0 1 0",
                     rf_write_o, ex_ready_o, rf_write_data_o);
        end
    endtask

    task automatic test_random();
        bit          is_load, rw, legal, exp_wr;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] addr, rdata, exp_data;
        int          gd, rvd;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            is_load = ($urandom_range(0, 2) != 0);
            rw      = ($urandom_range(0, 3) != 0);
            rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            f3      = 3'($urandom_range(0, 7));
            addr    = $urandom;
            rdata   = $urandom;
            exp_wr  = rw && (rd != 5'd0);
            issue(is_load, rw, f3, rd, addr);
            if (!is_load) begin
                exp_data = addr;
            end else begin
                legal = ref_legal(f3, addr);
                if (!legal) begin
                    checks++;
                    if (load_err_o !== 1'b1 || mem_req_o !== 1'b0 || rf_write_o !== 1'b0 || ex_ready_o !== 1'b1) begin
                        failures++;
                        $display("FAIL rnd_illegal[%0d]: f3=%0d addr=%h err=%b req=%b wr=%b ready=%b, required 1 0 0 1",
                                 it, f3, addr, load_err_o, mem_req_o, rf_write_o, ex_ready_o);
                    end
                    continue;
                end
                checks++;
                if (mem_req_o !== 1'b1 || mem_addr_o !== (addr - (addr % 4)) || load_err_o !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_req[%0d]: req=%b addr=%h err=%b, required 1 %h 0",
                             it, mem_req_o, mem_addr_o, load_err_o, addr - (addr % 4));
                end
                gd  = $urandom_range(0, 3);
                rvd = $urandom_range(0, 2);
                serve_mem(gd, rvd, rdata);
                exp_data = ref_load(rdata, f3, addr);
            end
            if (exp_wr) begin
                last_reg  = rd;
                last_data = exp_data;
            end
            checks++;
            if (rf_write_o !== exp_wr || rf_write_reg_o !== last_reg || rf_write_data_o !== last_data ||
                ex_ready_o !== 1'b1 || load_err_o !== 1'b0) begin
                failures++;
                $display("FAIL rnd_write[%0d]: load=%b f3=%0d addr=%h wr=%b reg=%0d data=%h ready=%b, required wr=%b reg=%0d data=%h ready=1",
                         it, is_load, f3, addr, rf_write_o, rf_write_reg_o, rf_write_data_o, ex_ready_o,
                         exp_wr, last_reg, last_data);
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        reset_i        = 1'b1;
        ex_valid_i     = 1'b0;
        ex_reg_write_i = 1'b0;
        ex_is_load_i   = 1'b0;
        ex_funct3_i    = 3'b000;
        ex_rd_i        = 5'd0;
        ex_result_i    = 32'd0;
        mem_gnt_i      = 1'b0;
        mem_rvalid_i   = 1'b0;
        mem_rdata_i    = 32'd0;
        last_reg       = 5'd0;
        last_data      = 32'd0;

        test_reset();
        test_alu();
        test_loads();
        test_illegal();
        test_gnt_delay();
        test_reset_inflight();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Sits directly upstream of the 32x32 register file and drives its single write port.
- Accepts completed instructions from execute via a valid/ready handshake.
- ALU results are forwarded to the write port directly.
- Loads issue one data-memory read (req/gnt, then rvalid). Returned data is aligned and sign- or zero-extended, then written. Only one load is outstanding at a time.

Parameters:
- DATA_W, 32, datapath and memory word width (only 32 is supported).
- REG_ADDR_W, 5, register index width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- ex_valid_i  in  1  execute result valid.
- ex_ready_o  out  1  stage can accept an instruction.
- ex_reg_write_i  in  1  instruction writes rd.
- ex_is_load_i  in  1  instruction is a load.
- ex_funct3_i  in  3  load type (RV32I encoding).
- ex_rd_i  in  REG_ADDR_W  destination register.
- ex_result_i  in  DATA_W  ALU result, or byte address for loads.
- mem_req_o  out  1  memory read request.
- mem_addr_o  out  DATA_W  word-aligned address, {addr[31:2],2'b00}.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DATA_W  read data.
- rf_write_o  out  1  register file write enable.
- rf_write_reg_o  out  REG_ADDR_W  write index.
- rf_write_data_o  out  DATA_W  write data.
- load_err_o  out  1  one-cycle pulse on an illegal or misaligned load.

Behaviour:
- Reset (asynchronous):
  - FSM goes to IDLE.
  - All outputs go to 0, except ex_ready_o, which is 1 while in IDLE.
  - Any in-flight load is abandoned: no write, mem_req_o drops immediately.
- FSM states: IDLE, REQ, WAIT.
- ex_ready_o = (state == IDLE). A transfer occurs when ex_valid_i && ex_ready_o.
- IDLE, non-load transfer:
  - If ex_reg_write_i && ex_rd_i != 0, rf_write_o pulses in the next cycle with ex_rd_i and ex_result_i.
  - Otherwise no write. State stays IDLE.
- IDLE, load transfer:
  - Capture rd, funct3, addr[1:0] and the aligned address.
  - Legal funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Illegal funct3 (011/110/111), LH/LHU with addr[0]=1, or LW with addr[1:0]!=0: load_err_o pulses next cycle, no memory access, no write, stay IDLE.
  - Otherwise go to REQ.
- REQ:
  - mem_req_o=1, mem_addr_o held stable until mem_gnt_i.
  - mem_gnt_i moves to WAIT. mem_req_o is 0 in WAIT.
- WAIT:
  - mem_rvalid_i is legal at the earliest one cycle after gnt.
  - On mem_rvalid_i, the lane is selected by offset:
    - byte: rdata[8*off +: 8]
    - half: rdata[16*off[1] +: 16]
  - Then sign-extend (LB/LH), zero-extend (LBU/LHU), or pass through (LW).
  - rf_write_o pulses next cycle if reg_write && rd != 0. Return to IDLE.
- mem_rvalid_i outside WAIT is ignored. mem_gnt_i outside REQ is ignored.
- Latency:
  - ALU: accept at cycle N -> write at N+1.
  - Load with gnt at N+1 and rvalid at N+2 -> write at N+3.
  - Next accept possible at N+3, giving back-to-back loads every 3 cycles minimum.
- Write to x0 is never issued: rf_write_o stays 0.
- rf_write_o and load_err_o are single-cycle pulses. rf_write_reg_o and rf_write_data_o hold their last value between writes.

Decomposition:
- Package wb_pkg holds:
  - wb_state_e {IDLE, REQ, WAIT};
  - funct3 localparams F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - DATA_W and REG_ADDR_W defaults.
- Sub-module load_aligner: purely combinational. Inputs rdata, funct3, offset; output is the extended 32-bit value. Used by writeback_stage.

Test Plan:
- ALU op rd=5, result=0xDEADBEEF, reg_write=1 -> next cycle rf_write_o=1, reg=5, data=0xDEADBEEF; rd=0 repeat -> rf_write_o stays 0.
- LB addr=0x1003, rdata=0x80FF_1234 -> mem_addr_o=0x1000, write data 0xFFFFFF80; LBU with same stimulus -> 0x00000080.
- LH addr=0x2002, rdata=0x9ABC_5678 -> 0xFFFF9ABC; LHU -> 0x00009ABC; LW addr=0x2000 -> 0x9ABC5678.
- LW addr=0x2001 -> load_err_o pulse, mem_req_o never asserted, no write, ex_ready_o stays 1; funct3=011 gives the same result.
- Gnt delayed 4 cycles -> mem_req_o and mem_addr_o stable throughout, ex_ready_o=0 until write; stray mem_rvalid_i in IDLE -> no write.
- reset_i asserted in WAIT -> mem_req_o=0, later rvalid ignored, no rf_write_o, ex_ready_o=1 after reset releases.
